// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner: row drive, column sync/debounce, one event per press.
// Optional auto-repeat while a key stays down is enabled by defining KEY_REPEAT_EN.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE_CNT = 4,
  parameter int unsigned REPEAT_DELAY = 200,
  parameter int unsigned REPEAT_RATE  = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] keypad_out,
  output logic       keypad_enable_out,
  output logic       key_held
);

  localparam int unsigned SlotW = $clog2(SCAN_DIV);
  localparam int unsigned DbW   = $clog2(DEBOUNCE_CNT + 1);

  if (SCAN_DIV < 2 || DEBOUNCE_CNT < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
    $error("keypad_scanner: parameter out of range");
  end

  typedef enum logic [1:0] {StScan, StDebounce, StPressed, StRelease} state_e;

  state_e           state;
  logic [3:0]       col_s1, col_s2;
  logic [SlotW-1:0] slot_cnt;
  logic [1:0]       row_idx;
  logic [3:0]       col_pat;
  logic [DbW-1:0]   db_cnt;
  logic             sample;

  assign sample  = (slot_cnt == SlotW'(SCAN_DIV - 1));
  assign row_out = ~(4'b0001 << row_idx);

  function automatic logic single_low(input logic [3:0] c);
    return c inside {4'b1110, 4'b1101, 4'b1011, 4'b0111};
  endfunction

  function automatic logic [1:0] col_index(input logic [3:0] pat);
    case (pat)
      4'b1101: return 2'd1;
      4'b1011: return 2'd2;
      4'b0111: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

`ifdef KEY_REPEAT_EN
  localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RptW   = $clog2(RptMax + 1);

  logic [RptW-1:0] rpt_cnt;
  logic [RptW-1:0] rpt_next;
  logic            rpt_armed;   // first repeat already emitted, now using REPEAT_RATE
  logic            rpt_fire;

  assign rpt_next = rpt_cnt + 1'b1;
  assign rpt_fire = rpt_armed ? (rpt_next == RptW'(REPEAT_RATE))
                              : (rpt_next == RptW'(REPEAT_DELAY));
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_s1   <= 4'b1111;
      col_s2   <= 4'b1111;
      slot_cnt <= '0;
    end else begin
      col_s1   <= col_in;
      col_s2   <= col_s1;
      slot_cnt <= sample ? '0 : slot_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= StScan;
      row_idx           <= 2'd0;
      col_pat           <= 4'b1111;
      db_cnt            <= '0;
      keypad_out        <= 4'd0;
      keypad_enable_out <= 1'b0;
      key_held          <= 1'b0;
`ifdef KEY_REPEAT_EN
      rpt_cnt           <= '0;
      rpt_armed         <= 1'b0;
`endif
    end else begin
      keypad_enable_out <= 1'b0;
      unique case (state)
        StScan: begin
          if (sample) begin
            if (single_low(col_s2)) begin
              state   <= StDebounce;
              col_pat <= col_s2;
              db_cnt  <= DbW'(1);
            end else begin
              row_idx <= row_idx + 2'd1;
            end
          end
        end
        StDebounce: begin
          if (db_cnt == DbW'(DEBOUNCE_CNT)) begin
            state             <= StPressed;
            keypad_out        <= {row_idx, col_index(col_pat)};
            keypad_enable_out <= 1'b1;
            key_held          <= 1'b1;
`ifdef KEY_REPEAT_EN
            rpt_cnt           <= '0;
            rpt_armed         <= 1'b0;
`endif
          end else if (sample) begin
            if (col_s2 == col_pat) begin
              db_cnt <= db_cnt + 1'b1;
            end else begin
              state   <= StScan;
              row_idx <= row_idx + 2'd1;
            end
          end
        end
        StPressed: begin
          if (sample) begin
            if (col_s2 == 4'b1111) begin
              state  <= StRelease;
              db_cnt <= DbW'(1);
            end
`ifdef KEY_REPEAT_EN
            else if (rpt_fire) begin
              rpt_cnt           <= '0;
              rpt_armed         <= 1'b1;
              keypad_enable_out <= !keypad_enable_out;  // never two strobes back to back
            end else begin
              rpt_cnt <= rpt_next;
            end
`endif
          end
        end
        StRelease: begin
          if (db_cnt == DbW'(DEBOUNCE_CNT)) begin
            state    <= StScan;
            key_held <= 1'b0;
            row_idx  <= row_idx + 2'd1;
          end else if (sample) begin
            if (col_s2 == 4'b1111) begin
              db_cnt <= db_cnt + 1'b1;
            end else begin
              state <= StPressed;
            end
          end
        end
        default: state <= StScan;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 key matrix driven from row_out.
// Build with KEY_REPEAT_EN defined to also exercise the auto-repeat timing.
module tb_keypad_scanner;

  localparam int unsigned SD = 4;
  localparam int unsigned DB = 3;
  localparam int unsigned RD = 5;
  localparam int unsigned RR = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic [3:0]  keypad_out;
  logic        keypad_enable_out;
  logic        key_held;
  logic [15:0] keys = 16'h0000;   // bit r*4+c set = key at row r, col c pressed

  int n_checks = 0;
  int n_errors = 0;
  int cyc;
  int pulse_cnt = 0;
  int pulse_cyc[$];
  int held_fall = -1;
  int back2back = 0;
  logic prev_en = 1'b0;
  logic prev_held = 1'b0;

  keypad_scanner #(
    .SCAN_DIV    (SD),
    .DEBOUNCE_CNT(DB),
    .REPEAT_DELAY(RD),
    .REPEAT_RATE (RR)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .col_in           (col_in),
    .row_out          (row_out),
    .keypad_out       (keypad_out),
    .keypad_enable_out(keypad_enable_out),
    .key_held         (key_held)
  );

  always #5 clk = ~clk;

  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!row_out[r] && keys[r*4+c]) col_in[c] = 1'b0;
      end
    end
  end

  // Cycle index: after the k-th rising edge following reset release, cyc == k.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  always @(posedge clk) begin
    #1;
    if (!reset) begin
      if (keypad_enable_out) begin
        pulse_cnt++;
        pulse_cyc.push_back(cyc);
        if (prev_en) back2back++;
      end
      if (prev_held && !key_held) held_fall = cyc;
    end
    prev_en   = keypad_enable_out;
    prev_held = key_held;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_row"},  row_out,           4'hE);
    check({tag, "_code"}, keypad_out,        4'h0);
    check({tag, "_en"},   keypad_enable_out, 1'b0);
    check({tag, "_held"}, key_held,          1'b0);
  endtask

  task automatic do_reset(input logic [15:0] k);
    reset = 1'b1;
    keys  = k;
    @(posedge clk);
    #1;
    check_reset_outputs("rst");
    pulse_cnt = 0;
    pulse_cyc.delete();
    held_fall = -1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_row;

    // Idle scanning: each row held for SD clocks, no events.
    do_reset(16'h0000);
    for (int k = 1; k <= 64; k++) begin
      wait_cyc(k);
      exp_row = ~(4'b0001 << ((k / 4) % 4));
      check("idle_row", row_out, exp_row);
    end
    check("idle_pulses", pulse_cnt, 0);

    // Key 6 (row 1, col 2): first low sample at edge 8, strobe at edge 17.
    do_reset(16'h0040);
    wait_cyc(16);
    check("press_en_early", keypad_enable_out, 1'b0);
    wait_cyc(17);
    check("press_en", keypad_enable_out, 1'b1);
    check("press_code", keypad_out, 4'd6);
    check("press_held", key_held, 1'b1);
    wait_cyc(18);
    check("press_en_drop", keypad_enable_out, 1'b0);
    wait_cyc(117);
    keys = 16'h0000;
    // First high sample at edge 120, release completes at edge 129.
    wait_cyc(128);
    check("rel_held_early", key_held, 1'b1);
    wait_cyc(129);
    check("rel_held", key_held, 1'b0);
    check("rel_row", row_out, 4'b1011);
    check("rel_code_kept", keypad_out, 4'd6);
    wait_cyc(140);
    check("one_pulse", pulse_cnt, 1);
    check("held_fall_cyc", held_fall, 129);
    if (pulse_cyc.size() > 0) check("pulse_cyc", pulse_cyc[0], 17);

    // Bounce: low at samples 8 and 12, high at 16 -> discarded, row advances to 2 at edge 16.
    do_reset(16'h0010);
    wait_cyc(13);
    keys = 16'h0000;
    wait_cyc(17);
    keys = 16'h0010;
    wait_cyc(21);
    keys = 16'h0000;
    wait_cyc(30);
    check("bounce_row30", row_out, 4'b1101);
    wait_cyc(42);
    check("bounce_row42", row_out, 4'b1110);
    check("bounce_pulses", pulse_cnt, 0);
    check("bounce_held", key_held, 1'b0);

    // Ghost: cols 0 and 3 on row 3 together -> ignored, normal scan schedule.
    do_reset(16'h9000);
    wait_cyc(78);
    check("ghost_row78", row_out, 4'b0111);
    wait_cyc(80);
    check("ghost_row80", row_out, 4'b1110);
    check("ghost_pulses", pulse_cnt, 0);
    check("ghost_held", key_held, 1'b0);

    // Asynchronous reset while PRESSED, then the still-held key is found again.
    do_reset(16'h0040);
    wait_cyc(20);
    check("pre_rst_held", key_held, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    do_reset(16'h0040);
    wait_cyc(17);
    check("repress_en", keypad_enable_out, 1'b1);
    check("repress_code", keypad_out, 4'd6);

`ifdef KEY_REPEAT_EN
    // Key 15: entry strobe at edge 25, first repeat 5 samples later (44), then every 2 (52, 60, 68).
    do_reset(16'h8000);
    wait_cyc(70);
    check("rpt_pulses", pulse_cnt, 5);
    check("rpt_code", keypad_out, 4'hF);
    if (pulse_cyc.size() >= 4) begin
      check("rpt_cyc0", pulse_cyc[0], 25);
      check("rpt_cyc1", pulse_cyc[1], 44);
      check("rpt_cyc2", pulse_cyc[2], 52);
      check("rpt_cyc3", pulse_cyc[3], 60);
    end else begin
      check("rpt_count_min", pulse_cyc.size(), 4);
    end
`endif

    check("no_back_to_back", back2back, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
